fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port br_sel  input  1  from the control unit; 1 selects the redirect target at consume.
REQ-005 SHALL have port alu_data  input  32  redirect target (ALU result).
REQ-006 SHALL have port stall  input  1  downstream hold; 1 blocks consume.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-008 SHALL have port imem_addr  output  32  read address, valid while imem_req=1.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid.
REQ-010 SHALL have port imem_rdata  input  32  read data.
REQ-011 SHALL have port inst  output  32  registered instruction to the control unit.
REQ-012 SHALL have port inst_valid  output  1  inst holds a fetched, unconsumed instruction.
REQ-013 SHALL have port pc  output  32  address of inst.
REQ-014 SHALL have port pc_four  output  32  pc+4 (JAL/JALR writeback), modulo 2^32.
REQ-015 SHALL have port misalign_err  output  1  sticky misaligned-target flag.
REQ-016 SHALL have port fetch_cnt  output  32  retired-instruction count (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, HOLD, ERROR.
REQ-018 IDLE SHALL last exactly one cycle, then go to FETCH; imem_rvalid in IDLE SHALL be ignored.
REQ-019 FETCH SHALL assert imem_req=1 with imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL hold until imem_rvalid=1, then latch inst<=imem_rdata, set inst_valid=1 and go to HOLD.
REQ-021 imem_rvalid in any state other than WAIT SHALL be ignored.
REQ-022 Consume SHALL occur on a HOLD cycle with stall=0: inst_valid<=0, pc updated, next state FETCH.
REQ-023 At consume, br_sel=0 SHALL give pc<=pc+4, and br_sel=1 SHALL give pc<={alu_data[31:1],1'b0}.
REQ-024 br_sel and alu_data SHALL be sampled only at consume.
REQ-025 HOLD with stall=1 SHALL keep inst, pc and inst_valid unchanged and SHALL NOT assert imem_req.
REQ-026 Minimum throughput SHALL be one instruction per 3 cycles: FETCH, WAIT with rvalid, HOLD with stall=0.
REQ-027 pc+4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000, with no error.
REQ-028 A redirect target with bit1=1 after bit0 clearing SHALL set misalign_err=1, leave pc unchanged and enter ERROR.
REQ-029 ERROR SHALL be left only by rst, and SHALL hold imem_req=0 and inst_valid=0.
REQ-030 When inst_valid=0, inst SHALL equal 32'h0000_0013 (NOP).
REQ-031 imem_addr SHALL equal pc in every state.

Reset
REQ-032 rst=1 at a clock edge SHALL set state=IDLE, pc=RESET_PC, inst=32'h0000_0013, inst_valid=0, imem_req=0, misalign_err=0, fetch_cnt=0.
REQ-033 rst in any state, including WAIT with a request outstanding, SHALL abandon the transaction; a late rvalid is dropped per REQ-018.
REQ-034 pc_four SHALL equal RESET_PC+4 after reset.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: fetch_cnt SHALL increment by 1 on every consume, wrapping at 2^32.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: fetch_cnt SHALL be constant 0, with no counter register.

Verification
REQ-037 Reset, rvalid 1 cycle after req with rdata=32'h00500093, stall=0: imem_req at cycle 2; inst_valid=1 with that inst at cycle 4; next imem_addr=0x4.
REQ-038 HOLD, stall=1 for 5 cycles: inst, pc and inst_valid stable and imem_req=0; after stall=0, next req at pc+4.
REQ-039 Consume with br_sel=1, alu_data=32'h0000_0101: pc becomes 0x100.
REQ-040 Consume with br_sel=1, alu_data=32'h0000_0102: misalign_err=1, ERROR entered, no further requests until rst.
REQ-041 pc=0xFFFF_FFFC, consume with br_sel=0: pc=0x0 and pc_four=0x4.
REQ-042 rst during WAIT, stale rvalid in the following cycle: inst_valid stays 0, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN defined, fetch_cnt=3 after 3 consumes.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit and its surroundings: control-unit redirect,
// downstream stall, instruction-memory read port and the fetched instruction.
interface fetch_unit_if;
    logic        br_sel;
    logic [31:0] alu_data;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    modport master (
        input  br_sel, alu_data, stall, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, inst, inst_valid, pc, pc_four,
        misalign_err, fetch_cnt
    );

    modport slave (
        output br_sel, alu_data, stall, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, inst, inst_valid, pc, pc_four,
        misalign_err, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE/FETCH/WAIT/HOLD/ERROR FSM.
// Optional FETCH_PERF_CNT_EN adds a wrapping retired-instruction counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_pc;
    logic [31:0] r_pc_four;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_misalign_err;

    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_consume;

    // Next-pc selection; only meaningful on a consume cycle.
    always_comb begin
        w_target  = {bus.alu_data[31:1], 1'b0};
        w_consume = (r_state == HOLD) && !bus.stall;
        if (bus.br_sel) begin
            w_next_pc  = w_target;
            w_misalign = w_target[1];
        end else begin
            w_next_pc  = r_pc + 32'd4;
            w_misalign = 1'b0;
        end
    end

    // Fetch FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_imem_req     <= 1'b0;
            r_pc           <= RESET_PC;
            r_pc_four      <= RESET_PC + 32'd4;
            r_inst         <= NOP;
            r_inst_valid   <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                FETCH: begin
                    r_state    <= WAIT;
                    r_imem_req <= 1'b0;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_consume) begin
                        r_inst_valid <= 1'b0;
                        r_inst       <= NOP;
                        if (w_misalign) begin
                            // pc is kept pointing at the offending branch
                            r_misalign_err <= 1'b1;
                            r_state        <= ERROR;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_pc_four  <= w_next_pc + 32'd4;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                end
                ERROR: begin
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_inst       <= NOP;
                end
                default: begin
                    r_state      <= ERROR;
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_inst       <= NOP;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;

    // Retired-instruction counter, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_consume) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign bus.fetch_cnt = r_fetch_cnt;
`else
    assign bus.fetch_cnt = 32'd0;
`endif

    assign bus.imem_req     = r_imem_req;
    assign bus.imem_addr    = r_pc;
    assign bus.inst         = r_inst;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.pc           = r_pc;
    assign bus.pc_four      = r_pc_four;
    assign bus.misalign_err = r_misalign_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level pc/count model.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_pc;
    int unsigned m_cnt;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.br_sel = 1'b0;
        bus.alu_data = 32'd0;
        bus.stall = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = RST_PC;
        m_cnt = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_timeout: no imem_req within 20 cycles, expected one at addr %h", m_pc);
        end
    endtask

    // One full instruction: request, rvalid after lat cycles, stall_n hold cycles, consume.
    task automatic fetch_one(input logic [31:0] rdata, input int lat, input int stall_n,
                             input logic br, input logic [31:0] alu);
        bit          ok;
        logic [31:0] npc;
        bit          bad;
        wait_req(ok);
        if (!ok) return;
        checks++;
        if (bus.imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr: imem_addr=%h expected %h", bus.imem_addr, m_pc);
        end
        bus.imem_rvalid = 1'($urandom_range(0, 1));
        bus.imem_rdata  = $urandom;
        @(negedge clk);
        repeat (lat - 1) begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL wait_state: inst_valid=%b imem_req=%b expected 0 0", bus.inst_valid, bus.imem_req);
            end
            @(negedge clk);
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rdata;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== rdata) begin
            errors++;
            $display("FAIL hold_inst: inst_valid=%b inst=%h expected 1 %h", bus.inst_valid, bus.inst, rdata);
        end
        checks++;
        if (bus.pc !== m_pc || bus.pc_four !== m_pc + 32'd4) begin
            errors++;
            $display("FAIL hold_pc: pc=%h pc_four=%h expected %h %h", bus.pc, bus.pc_four, m_pc, m_pc + 32'd4);
        end
        bus.stall = 1'b1;
        repeat (stall_n) begin
            bus.br_sel   = 1'($urandom_range(0, 1));
            bus.alu_data = $urandom;
            @(negedge clk);
            checks++;
            if (bus.inst !== rdata || bus.inst_valid !== 1'b1 || bus.pc !== m_pc || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: inst=%h valid=%b pc=%h req=%b expected %h 1 %h 0",
                         bus.inst, bus.inst_valid, bus.pc, bus.imem_req, rdata, m_pc);
            end
        end
        bus.stall    = 1'b0;
        bus.br_sel   = br;
        bus.alu_data = alu;
        npc = br ? {alu[31:1], 1'b0} : m_pc + 32'd4;
        bad = br && npc[1];
        m_cnt++;
        @(negedge clk);
        bus.br_sel   = 1'($urandom_range(0, 1));
        bus.alu_data = $urandom;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== NOP) begin
            errors++;
            $display("FAIL consume_clear: inst_valid=%b inst=%h expected 0 %h", bus.inst_valid, bus.inst, NOP);
        end
        if (bad) begin
            checks++;
            if (bus.misalign_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== m_pc) begin
                errors++;
                $display("FAIL misalign: err=%b req=%b pc=%h expected 1 0 %h", bus.misalign_err, bus.imem_req, bus.pc, m_pc);
            end
        end else begin
            m_pc = npc;
            checks++;
            if (bus.misalign_err !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc ||
                bus.pc !== m_pc || bus.pc_four !== m_pc + 32'd4) begin
                errors++;
                $display("FAIL consume_pc: err=%b req=%b addr=%h pc=%h pc_four=%h expected 0 1 %h %h %h",
                         bus.misalign_err, bus.imem_req, bus.imem_addr, bus.pc, bus.pc_four, m_pc, m_pc, m_pc + 32'd4);
            end
        end
        checks++;
        if (bus.fetch_cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL fetch_cnt: got %0d expected %0d", bus.fetch_cnt, exp_cnt());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b inst=%h err=%b expected 0 0 %h 0",
                     bus.imem_req, bus.inst_valid, bus.inst, bus.misalign_err, NOP);
        end
        checks++;
        if (bus.pc !== RST_PC || bus.pc_four !== RST_PC + 32'd4 || bus.imem_addr !== RST_PC || bus.fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_pc: pc=%h pc_four=%h addr=%h cnt=%0d expected %h %h %h 0",
                     bus.pc, bus.pc_four, bus.imem_addr, bus.fetch_cnt, RST_PC, RST_PC + 32'd4, RST_PC);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_c1: imem_req=%b expected 0", bus.imem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_c2: req=%b addr=%h valid=%b expected 1 %h 0", bus.imem_req, bus.imem_addr, bus.inst_valid, RST_PC);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_c3: req=%b valid=%b expected 0 0", bus.imem_req, bus.inst_valid);
        end
        bus.imem_rdata = 32'h0050_0093;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0050_0093 || bus.pc !== RST_PC) begin
            errors++;
            $display("FAIL basic_c4: valid=%b inst=%h pc=%h expected 1 00500093 %h", bus.inst_valid, bus.inst, bus.pc, RST_PC);
        end
        @(negedge clk);
        m_pc = RST_PC + 32'd4;
        m_cnt = 1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0004 || bus.fetch_cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL basic_c5: req=%b addr=%h cnt=%0d expected 1 00000004 %0d", bus.imem_req, bus.imem_addr, bus.fetch_cnt, exp_cnt());
        end
    endtask

    task automatic test_stall();
        fetch_one($urandom, 1, 5, 1'b0, 32'd0);
    endtask

    task automatic test_branch();
        fetch_one($urandom, 2, 0, 1'b1, 32'h0000_0101);
        checks++;
        if (bus.pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL branch_target: pc=%h expected 00000100", bus.pc);
        end
        fetch_one($urandom, 1, 0, 1'b0, 32'd0);
    endtask

    task automatic test_wrap();
        fetch_one($urandom, 1, 1, 1'b1, 32'hFFFF_FFFD);
        fetch_one($urandom, 1, 0, 1'b0, 32'd0);
        checks++;
        if (bus.pc !== 32'h0000_0000 || bus.pc_four !== 32'h0000_0004 || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap: pc=%h pc_four=%h err=%b expected 00000000 00000004 0", bus.pc, bus.pc_four, bus.misalign_err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [31:0] alu;
            alu = $urandom;
            alu[1] = 1'b0;
            fetch_one($urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 2) == 0), alu);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] held_pc;
        held_pc = m_pc;
        fetch_one($urandom, 1, 0, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 10; i++) begin
            bus.imem_rvalid = 1'($urandom_range(0, 1));
            bus.imem_rdata  = $urandom;
            @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b0 || bus.misalign_err !== 1'b1 || bus.inst_valid !== 1'b0 || bus.pc !== held_pc) begin
                errors++;
                $display("FAIL error_state: req=%b err=%b valid=%b pc=%h expected 0 1 0 %h",
                         bus.imem_req, bus.misalign_err, bus.inst_valid, bus.pc, held_pc);
            end
        end
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset_wait();
        bit ok;
        do_reset();
        wait_req(ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        m_pc = RST_PC;
        m_cnt = 0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_wait: valid=%b inst=%h req=%b addr=%h expected 0 %h 1 %h",
                     bus.inst_valid, bus.inst, bus.imem_req, bus.imem_addr, NOP, RST_PC);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_one($urandom, 1, 0, 1'b0, 32'd0);
        end
        checks++;
`ifdef FETCH_PERF_CNT_EN
        if (bus.fetch_cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_three: fetch_cnt=%0d expected 3", bus.fetch_cnt);
        end
`else
        if (bus.fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_zero: fetch_cnt=%0d expected 0", bus.fetch_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap();
        test_random();
        test_misalign();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
